fifo_push_arbiter: RTL

Round-robin arbiter that shares the push port of a single flip-flop FIFO (width/depth-parameterised, push/pop/full/empty interface) between N producers. Each producer uses a valid/ready handshake. The arbiter picks at most one producer per cycle, drives `push`/`write_data` into the FIFO, and reports the granted producer index. A burst limit lets a producer hold the port for up to BURST consecutive pushes before rotation is forced.

---
 rtl/fifo_push_arbiter_pkg.sv | 28 ++
 rtl/fifo_push_arbiter_if.sv | 33 +++
 rtl/fifo_push_arbiter_rr_priority_pick.sv | 32 +++
 rtl/fifo_push_arbiter.sv | 93 +++++++++
 4 files changed

// File: rtl/fifo_push_arbiter_pkg.sv
// Shared definitions for the FIFO push arbiter: width helpers and the
// wrap-around index increment used by the round-robin rotation.
package fifo_arb_pkg;

  // Default configuration of the arbiter.
  localparam int unsigned N_REQ_DEF = 3;
  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned BURST_DEF = 2;

  // Width of a producer index (at least one bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width of the burst counter, able to hold the value 'burst'.
  function automatic int unsigned cnt_w(input int unsigned b);
    return (b < 1) ? 1 : $clog2(b + 1);
  endfunction

  localparam int unsigned IDX_W_DEF = idx_w(N_REQ_DEF);
  localparam int unsigned CNT_W_DEF = cnt_w(BURST_DEF);

  // Wrap-around increment: (idx + 1) mod n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_push_arbiter_if.sv
// Producer and FIFO-push signal bundle of the arbiter.
//
// Handshake: producer i offers data with req_valid[i]; the arbiter answers
// with req_ready[i] in the same cycle (combinationally). A transfer for i
// happens on the rising clock edge where req_valid[i] & req_ready[i] is 1,
// which is also the edge where push=1 writes write_data into the FIFO.
// At most one req_ready bit is set. fifo_full must come from a register.
interface fifo_push_arbiter_if #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned IDX_W = fifo_arb_pkg::idx_w(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   fifo_full;
  logic                   push;
  logic [WIDTH-1:0]       write_data;
  logic [IDX_W-1:0]       grant_id;

  // Arbiter side.
  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, push, write_data, grant_id
  );

  // Producers plus FIFO side.
  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, push, write_data, grant_id
  );
endinterface

// File: rtl/fifo_push_arbiter_rr_priority_pick.sv
// Rotating first-one finder: the first set bit of vec scanning from start
// upwards and wrapping around.
module rr_priority_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N = 3,
  localparam int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  vec,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  int pos;

  // Walk N positions from start, keep the first valid one.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int k = 0; k < int'(N); k++) begin
      pos = int'(start) + k;
      if (pos >= int'(N)) pos = pos - int'(N);
      if (!found && vec[pos[IW-1:0]]) begin
        found = 1'b1;
        idx   = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port among n_req producers,
// with a burst limit on consecutive pushes by the same producer.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned n_req = 3,
  parameter int unsigned width = 8,
  parameter int unsigned burst = 2,
  localparam int unsigned IDX_W = idx_w(n_req),
  localparam int unsigned CNT_W = cnt_w(burst)
) (
  input  logic               clk,
  input  logic               rst,
  fifo_push_arbiter_if.master bus,
  output logic [IDX_W-1:0]   dbg_owner_o,
  output logic [CNT_W-1:0]   dbg_cnt_o
);

  logic [IDX_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] start_idx;
  logic             keep_owner;
  logic             found;
  logic [IDX_W-1:0] pick_idx;
  logic             grant;

  logic [n_req-1:0] req_ready_d;
  logic [width-1:0] write_data_d;

  // Current owner keeps scan priority while still valid and under its burst limit.
  always_comb begin
    keep_owner = bus.req_valid[owner_q] && (cnt_q < CNT_W'(burst));
    start_idx  = keep_owner ? owner_q : IDX_W'(rr_next(32'(owner_q), n_req));
  end

  rr_priority_pick #(.N(n_req)) u_pick (
    .vec   (bus.req_valid),
    .start (start_idx),
    .found (found),
    .idx   (pick_idx)
  );

  // A grant needs a valid producer, room in the FIFO and reset released.
  assign grant = found && !bus.fifo_full && rst;

  // Output muxing; everything is zero when there is no grant.
  always_comb begin
    req_ready_d  = '0;
    write_data_d = '0;
    if (grant) begin
      for (int i = 0; i < int'(n_req); i++) begin
        if (pick_idx == IDX_W'(i)) begin
          req_ready_d[i] = 1'b1;
          write_data_d   = bus.req_data[i*width +: width];
        end
      end
    end
  end

  assign bus.req_ready  = req_ready_d;
  assign bus.push       = grant;
  assign bus.write_data = write_data_d;
  assign bus.grant_id   = grant ? pick_idx : '0;

  // Burst bookkeeping: continue the burst or hand the port to a new owner.
  always_comb begin
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (grant) begin
      if (keep_owner && (pick_idx == owner_q)) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        owner_d = pick_idx;
        cnt_d   = CNT_W'(1);
      end
    end
  end

  // State registers; reset makes the first scan start at producer 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q <= IDX_W'(n_req - 1);
      cnt_q   <= CNT_W'(burst);
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dbg_owner_o = owner_q;
  assign dbg_cnt_o   = cnt_q;

endmodule
